// File: rtl/patch_chk_pkg.sv
// Shared types and constants for the ECO patch sweep checker.
// Holds the FSM encoding, the patch input bit positions and the settle-latency helper.
package patch_chk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int IDX_A  = 0;
   localparam int IDX_B  = 1;
   localparam int IDX_C  = 2;
   localparam int IDX_G1 = 3;

   localparam int PIPE_LAT_MAX = 15;

   // Last settle count before sampling; latencies above the maximum are clamped.
   function automatic int settle_term(input int lat);
      int clamped;
      clamped = (lat > PIPE_LAT_MAX) ? PIPE_LAT_MAX : lat;
      return (clamped == 0) ? 0 : clamped - 1;
   endfunction

endpackage

// File: rtl/patch_settle_timer.sv
// 4-bit up/down counter with synchronous load and a terminal-count flag.
// Times the settle cycles between applying a vector and sampling the patch output.
module patch_settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       en,
   input  logic       dn,
   input  logic [3:0] load_val,
   input  logic [3:0] term_val,
   output logic       tc
);

   logic [3:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= dn ? count - 4'd1 : count + 4'd1;
      end
   end

   assign tc = (count == term_val);

endmodule

// File: rtl/patch_sweep_checker.sv
// Exhaustive sweep of the patch inputs against a golden truth table.
// Drives each vector, samples dut_out in its last cycle and accumulates mismatch results.
module patch_sweep_checker
   import patch_chk_pkg::*;
#(
   parameter int unsigned           N_IN     = 4,
   parameter int unsigned           PIPE_LAT = 1,
   parameter logic [2**N_IN-1:0]    GOLDEN   = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   output logic [N_IN-1:0] drv_vec,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   mism_cnt,
   output logic            first_fail_valid,
   output logic [N_IN-1:0] first_fail_vec,
   output state_t          state
);

   localparam logic [3:0]      SETTLE_TERM = 4'(settle_term(int'(PIPE_LAT)));
   localparam logic            NO_SETTLE   = (PIPE_LAT == 0);
   localparam logic [N_IN-1:0] LAST_IDX    = '1;

   state_t          next_state;
   logic [N_IN-1:0] idx;
   logic            timer_load;
   logic            timer_en;
   logic            timer_tc;
   logic            sweep_start;
   logic            do_sample;
   logic            do_abort;
   logic            mismatch;
   logic [N_IN:0]   mism_next;

   patch_settle_timer u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .en       (timer_en),
      .dn       (1'b0),
      .load_val (4'd0),
      .term_val (SETTLE_TERM),
      .tc       (timer_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // start and abort are single-cycle level commands, no ready: start is taken only in
   // IDLE/DONE, abort only in SETTLE/SAMPLE (and wins over that cycle's sample).
   always_comb begin
      next_state  = state;
      timer_load  = 1'b0;
      timer_en    = 1'b0;
      sweep_start = 1'b0;
      do_sample   = 1'b0;
      do_abort    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               sweep_start = 1'b1;
               timer_load  = 1'b1;
               next_state  = NO_SETTLE ? SAMPLE : SETTLE;
            end
         end
         SETTLE: begin
            if (abort) begin
               do_abort   = 1'b1;
               next_state = IDLE;
            end else begin
               timer_en = 1'b1;
               if (timer_tc) begin
                  next_state = SAMPLE;
               end
            end
         end
         SAMPLE: begin
            if (abort) begin
               do_abort   = 1'b1;
               next_state = IDLE;
            end else begin
               do_sample = 1'b1;
               if (idx == LAST_IDX) begin
                  next_state = DONE;
               end else if (!NO_SETTLE) begin
                  timer_load = 1'b1;
                  next_state = SETTLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign mismatch  = dut_out ^ GOLDEN[idx];
   assign mism_next = mism_cnt + {{N_IN{1'b0}}, mismatch};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx              <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         mism_cnt         <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else if (sweep_start || do_abort) begin
         idx              <= '0;
         busy             <= sweep_start;
         done             <= 1'b0;
         pass             <= 1'b0;
         mism_cnt         <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else if (do_sample) begin
         if (mismatch) begin
            mism_cnt <= mism_next;
            if (!first_fail_valid) begin
               first_fail_valid <= 1'b1;
               first_fail_vec   <= idx;
            end
         end
         // idx stays on the last vector so it never wraps and drv_vec is stable in DONE.
         if (idx == LAST_IDX) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (mism_next == '0);
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign drv_vec = idx;

endmodule

// File: tb/tb_patch_sweep_checker.sv
// Bench for patch_sweep_checker: a registered and a combinational patch model with fault masks,
// results checked against mask-derived expectations (popcount, lowest set bit).
module tb_patch_sweep_checker;
   import patch_chk_pkg::*;

   localparam logic [15:0] GOLD = 16'hA5C3;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;

   logic [3:0]  drv_vec1, drv_vec0;
   logic        dut_out1, dut_out0;
   logic        busy1, busy0, done1, done0, pass1, pass0;
   logic [4:0]  mism1, mism0;
   logic        ffv1, ffv0;
   logic [3:0]  ffvec1, ffvec0;
   state_t      state1, state0;

   logic [15:0] mask1, mask0;
   logic [3:0]  exp_q[$];

   int n_tests;
   int n_fail;
   int cyc1, cyc0;

   patch_sweep_checker #(.N_IN(4), .PIPE_LAT(1), .GOLDEN(GOLD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .drv_vec(drv_vec1), .dut_out(dut_out1), .busy(busy1), .done(done1), .pass(pass1),
      .mism_cnt(mism1), .first_fail_valid(ffv1), .first_fail_vec(ffvec1), .state(state1)
   );

   patch_sweep_checker #(.N_IN(4), .PIPE_LAT(0), .GOLDEN(GOLD)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .drv_vec(drv_vec0), .dut_out(dut_out0), .busy(busy0), .done(done0), .pass(pass0),
      .mism_cnt(mism0), .first_fail_valid(ffv0), .first_fail_vec(ffvec0), .state(state0)
   );

   // Clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Patch models: one-cycle registered patch and a purely combinational patch.
   always_ff @(posedge clk) begin
      dut_out1 <= GOLD[drv_vec1] ^ mask1[drv_vec1];
   end
   assign dut_out0 = GOLD[drv_vec0] ^ mask0[drv_vec0];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] lowest_set(input logic [15:0] m);
      for (int i = 0; i < 16; i++) begin
         if (m[i]) return 4'(i);
      end
      return 4'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts both checkers, optionally pulses start/abort at cycle st_at/ab_at, counts busy cycles.
   task automatic run_sweep(input int st_at, input int ab_at, output logic aborted);
      int last;
      aborted = 1'b0;
      exp_q.delete();
      for (int v = 0; v < 16; v++) exp_q.push_back(4'(v));
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc1 = 0;
      cyc0 = 0;
      last = -1;
      check("busy_after_start", {31'd0, busy1}, 32'd1);
      for (int k = 0; k < 200; k++) begin
         if (done1 && done0) break;
         if (busy1 && int'(drv_vec1) != last) begin
            check("vec_order", {28'd0, drv_vec1},
                  (exp_q.size() != 0) ? {28'd0, exp_q.pop_front()} : 32'hDEAD);
            last = int'(drv_vec1);
         end
         if (busy1) cyc1++;
         if (busy0) cyc0++;
         start = (k == st_at);
         abort = (k == ab_at);
         tick();
         start = 1'b0;
         if (abort) begin
            abort   = 1'b0;
            aborted = 1'b1;
            break;
         end
      end
      if (!aborted) check("vec_all_seen", exp_q.size(), 32'd0);
   endtask

   task automatic sweep_check(input string tag);
      check({tag, "_busy_cyc1"}, cyc1, 32'd32);
      check({tag, "_busy_cyc0"}, cyc0, 32'd16);
      check({tag, "_done1"}, {31'd0, done1}, 32'd1);
      check({tag, "_done0"}, {31'd0, done0}, 32'd1);
      check({tag, "_mism1"}, {27'd0, mism1}, $countones(mask1));
      check({tag, "_mism0"}, {27'd0, mism0}, $countones(mask0));
      check({tag, "_pass1"}, {31'd0, pass1}, {31'd0, mask1 == 16'd0});
      check({tag, "_pass0"}, {31'd0, pass0}, {31'd0, mask0 == 16'd0});
      check({tag, "_ffv1"}, {31'd0, ffv1}, {31'd0, mask1 != 16'd0});
      check({tag, "_ffv0"}, {31'd0, ffv0}, {31'd0, mask0 != 16'd0});
      if (mask1 != 16'd0) check({tag, "_ffvec1"}, {28'd0, ffvec1}, {28'd0, lowest_set(mask1)});
      if (mask0 != 16'd0) check({tag, "_ffvec0"}, {28'd0, ffvec0}, {28'd0, lowest_set(mask0)});
      check({tag, "_state1"}, {30'd0, state1}, {30'd0, DONE});
   endtask

   task automatic reset_check(input string tag);
      check({tag, "_vec"}, {28'd0, drv_vec1}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy1}, 32'd0);
      check({tag, "_busy0"}, {31'd0, busy0}, 32'd0);
      check({tag, "_done"}, {31'd0, done1}, 32'd0);
      check({tag, "_pass"}, {31'd0, pass1}, 32'd0);
      check({tag, "_mism"}, {27'd0, mism1}, 32'd0);
      check({tag, "_ffv"}, {31'd0, ffv1}, 32'd0);
      check({tag, "_ffvec"}, {28'd0, ffvec1}, 32'd0);
      check({tag, "_state"}, {30'd0, state1}, {30'd0, IDLE});
   endtask

   initial begin
      logic ab;
      logic [4:0]  mism_hold;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      mask1   = 16'd0;
      mask0   = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      reset_check("reset");
      rst_n = 1'b1;
      tick();

      // Golden match on the latency-1 patch, always-wrong patch on PIPE_LAT=0.
      mask1 = 16'd0;
      mask0 = 16'hFFFF;
      run_sweep(-1, -1, ab);
      sweep_check("golden");

      // Injected faults at vectors 5 and 12.
      mask1 = 16'h1020;
      mask0 = 16'd0;
      run_sweep(-1, -1, ab);
      sweep_check("inject");

      // Abort in DONE is ignored.
      mism_hold = mism1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_in_done_done", {31'd0, done1}, 32'd1);
      check("abort_in_done_mism", {27'd0, mism1}, {27'd0, mism_hold});

      // Randomized fault masks.
      for (int r = 0; r < 6; r++) begin
         mask1 = 16'($urandom_range(0, 16'hFFFF)) & 16'($urandom_range(0, 16'hFFFF));
         mask0 = 16'($urandom_range(0, 16'hFFFF));
         run_sweep(-1, -1, ab);
         sweep_check("random");
      end

      // Abort at cycle 10 after some mismatches are recorded, then a fresh sweep.
      mask1 = 16'h0003;
      mask0 = 16'h0001;
      run_sweep(-1, 10, ab);
      check("abort_taken", {31'd0, ab}, 32'd1);
      check("abort_busy", {31'd0, busy1}, 32'd0);
      check("abort_done", {31'd0, done1}, 32'd0);
      check("abort_mism", {27'd0, mism1}, 32'd0);
      check("abort_ffv", {31'd0, ffv1}, 32'd0);
      check("abort_state", {30'd0, state1}, {30'd0, IDLE});
      check("abort_mism0", {27'd0, mism0}, 32'd0);
      run_sweep(-1, -1, ab);
      sweep_check("after_abort");

      // start while busy is ignored; restarting from DONE repeats identically.
      mask1 = 16'h8410;
      mask0 = 16'h0240;
      run_sweep(7, -1, ab);
      sweep_check("start_busy");
      run_sweep(-1, -1, ab);
      sweep_check("restart");

      // Asynchronous reset in the middle of a SAMPLE cycle.
      mask1 = 16'hFFFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("pre_reset_state", {30'd0, state1}, {30'd0, SAMPLE});
      check("pre_reset_mism_nz", {31'd0, mism1 != 5'd0}, 32'd1);
      rst_n = 1'b0;
      #1;
      reset_check("async_reset");
      #2;
      rst_n = 1'b1;
      tick();
      mask1 = 16'd0;
      mask0 = 16'd0;
      run_sweep(-1, -1, ab);
      sweep_check("post_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/patch_sweep_checker.md
# patch_sweep_checker

Self-checking stimulus engine for an ECO patch netlist: drives every combination of the patch inputs (a, b, c, g1) into the patch under test, samples its single output and compares it against a golden truth table. It sits on the driving side of the patch interface: it produces what the patch consumes and consumes what the patch produces. It is used on-chip or in emulation to confirm a generated patch before sign-off.

## Interface
- N_IN, 4, number of patch inputs; vector bit 0=a, 1=b, 2=c, 3=g1.
- PIPE_LAT, 1, settle cycles between applying a vector and sampling dut_out; range 0..15.
- GOLDEN, {2**N_IN{1'b0}}, expected output; bit i is the expected dut_out for vector value i.

- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; accepted in IDLE or DONE, ignored otherwise.
- abort  in  1  cancel a sweep in progress.
- drv_vec  out  N_IN  vector driven to the patch inputs.
- dut_out  in  1  patch output, the w-output of the patch netlist.
- busy  out  1  sweep in progress.
- done  out  1  sweep completed; level, held until next start.
- pass  out  1  valid when done=1; 1 when mism_cnt==0.
- mism_cnt  out  N_IN+1  number of mismatching vectors.
- first_fail_valid  out  1  at least one mismatch recorded.
- first_fail_vec  out  N_IN  lowest-index failing vector.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 -> SETTLE; idx:=0, mism_cnt:=0, first_fail_valid:=0, settle count:=0.
- SETTLE: drv_vec=idx; count up; at count==PIPE_LAT-1 -> SAMPLE. PIPE_LAT=0: SETTLE is skipped, IDLE/DONE/SAMPLE go directly to SAMPLE.
- SAMPLE: drv_vec=idx; compare dut_out against GOLDEN[idx]. On mismatch, mism_cnt+=1; if first_fail_valid==0, latch first_fail_vec:=idx and set first_fail_valid. If idx==2**N_IN-1 -> DONE; else idx+=1 and go to SETTLE, or stay in SAMPLE if PIPE_LAT=0.
- DONE: done=1, pass=(mism_cnt==0). Results hold. start=1 -> new sweep, as from IDLE, with done dropping the next cycle.
- abort=1 in SETTLE/SAMPLE -> IDLE; results cleared; done=0. abort has priority over a sample in the same cycle, and the vector is not counted. abort in IDLE/DONE is ignored.
- start while busy is ignored.
- mism_cnt is N_IN+1 bits wide, so 2**N_IN mismatches cannot wrap; no saturation logic.
- idx is N_IN bits; the final increment is suppressed, so it never wraps.

## Timing
- Reset values: drv_vec=0, busy=0, done=0, pass=0, mism_cnt=0, first_fail_valid=0, first_fail_vec=0, state=IDLE.
- drv_vec, busy, done and pass are registered outputs.
- Each vector is held for exactly PIPE_LAT+1 cycles, and dut_out is sampled in the last of them.
- start high at edge 0 -> busy=1 and drv_vec=0 after edge 0.
- Sweep length: 2**N_IN*(PIPE_LAT+1) cycles busy, then done=1 on the following edge. Defaults: 32 busy cycles; done is observed after edge 32.
- drv_vec changes only on the edge that leaves SAMPLE, so the patch sees glitch-free vector boundaries.
- Asynchronous reset mid-sweep clears everything immediately; no partial results are retained.

## Structure
- Package patch_chk_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - input bit-index constants IDX_A=0, IDX_B=1, IDX_C=2, IDX_G1=3;
  - PIPE_LAT_MAX=15.
- One sub-module, patch_settle_timer: 4-bit down/up counter with load and terminal-count output, used for SETTLE. Everything else stays in the top.

## Test plan
- Golden match, defaults. Model the patch in the bench as dut_out=GOLDEN[drv_vec] delayed 1 cycle, with GOLDEN=16'hA5C3 -> done after 33 edges, pass=1, mism_cnt=0, first_fail_valid=0.
- Injected faults. Same setup, bench flips the output for vectors 5 and 12 -> mism_cnt=2, first_fail_vec=4'h5, pass=0.
- PIPE_LAT=0, always-wrong patch. Combinational model with inverted output -> busy for 16 cycles, mism_cnt=16 (5'h10), first_fail_vec=0.
- Abort. abort at cycle 10 of a sweep -> IDLE next edge, done=0, mism_cnt=0. Then start -> full fresh sweep with correct results.
- start while busy, then restart from DONE. start pulsed at cycle 7 is ignored and the sweep length is unchanged. start in DONE clears the results and repeats the sweep identically.
- Reset. rst_n low mid-SAMPLE -> all outputs at reset values asynchronously, before the next clk edge.
